control_sequencer: RTL and testbench

Fetch/decode/execute state machine for the 8-bit microprocessor. It sits directly upstream of the datapath block: it consumes `machine_code` (IR contents) and produces every register load/drive strobe, ALU select and bus-enable that the datapath expects. It also runs the external memory handshake.

---
 rtl/cpu_ctrl_pkg.sv | 57 +++++
 rtl/ctrl_decode.sv | 42 ++++
 rtl/control_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control path: opcodes, sequencer states,
// instruction classes and the ALU operand/operation encodings.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_MVG = 4'h7;
    localparam logic [3:0] OP_RDF = 4'h8;
    localparam logic [3:0] OP_RDG = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] SEL_AR = 2'b00;
    localparam logic [1:0] SEL_DR = 2'b01;
    localparam logic [1:0] SEL_GR = 2'b10;
    localparam logic [1:0] SEL_PR = 2'b11;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StOpnd,
        StMemRd,
        StMemWr,
        StAlu1,
        StAlu2,
        StXfer,
        StJump,
        StHalt
    } state_e;

    typedef enum logic [3:0] {
        ClsNop,
        ClsLda,
        ClsSta,
        ClsAdd,
        ClsSub,
        ClsLdi,
        ClsJmp,
        ClsMvg,
        ClsRdf,
        ClsRdg,
        ClsHlt
    } iclass_e;

    // States that own a memory access and therefore wait on mem_ready.
    function automatic logic is_bus_state(state_e s);
        return (s == StFetch) || (s == StOpnd) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: instruction class, operand fields and an
// illegal-opcode flag (illegal opcodes decode as NOP).
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [7:0] machine_code,
    output iclass_e    iclass,
    output logic [1:0] sel_a,
    output logic [1:0] sel_b,
    output logic       alu_op,
    output logic       gr_msb,
    output logic       illegal
);

    logic [3:0] opcode;

    assign opcode = machine_code[7:4];
    assign sel_a  = machine_code[3:2];
    assign sel_b  = machine_code[1:0];
    assign gr_msb = machine_code[0];
    assign alu_op = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;

    always_comb begin
        iclass  = ClsNop;
        illegal = 1'b0;
        case (opcode)
            OP_NOP:  iclass = ClsNop;
            OP_LDA:  iclass = ClsLda;
            OP_STA:  iclass = ClsSta;
            OP_ADD:  iclass = ClsAdd;
            OP_SUB:  iclass = ClsSub;
            OP_LDI:  iclass = ClsLdi;
            OP_JMP:  iclass = ClsJmp;
            OP_MVG:  iclass = ClsMvg;
            OP_RDF:  iclass = ClsRdf;
            OP_RDG:  iclass = ClsRdg;
            OP_HLT:  iclass = ClsHlt;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit CPU: state register, per-access
// memory wait counter with timeout, and Moore strobe decode for the datapath.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] machine_code,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       pr_on_add,
    output logic       ar_on_add,
    output logic       pr_on_data,
    output logic       ir_on_data,
    output logic       ar_on_data,
    output logic       dr_on_data,
    output logic       gr_on_data,
    output logic       alu_2_data,
    output logic       load_FR_On_data,
    output logic       data_on_ir,
    output logic       data_on_ar,
    output logic       data_on_dr,
    output logic       lsb_on_gr,
    output logic       msb_on_gr,
    output logic       ar_on_pr,
    output logic       increment_pr,
    output logic       ALU_sel,
    output logic       ALU_cin,
    output logic [1:0] add_sel_a,
    output logic [1:0] add_sel_b,
    output logic       halted,
    output logic       illegal_op,
    output logic       bus_timeout
);

    localparam int unsigned WaitW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             timeout_q, timeout_d;

    iclass_e    iclass;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       alu_op;
    logic       gr_msb;
    logic       illegal;

    ctrl_decode u_decode (
        .machine_code(machine_code),
        .iclass      (iclass),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .alu_op      (alu_op),
        .gr_msb      (gr_msb),
        .illegal     (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        timeout_d = timeout_q;
        unique case (state_q)
            StFetch: if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (iclass)
                    ClsLda, ClsSta, ClsLdi, ClsJmp: state_d = StOpnd;
                    ClsAdd, ClsSub:                 state_d = StAlu1;
                    ClsMvg, ClsRdf, ClsRdg:         state_d = StXfer;
                    ClsHlt:                         state_d = StHalt;
                    default:                        state_d = StFetch;
                endcase
            end
            StOpnd: begin
                if (mem_ready) begin
                    case (iclass)
                        ClsLda:  state_d = StMemRd;
                        ClsSta:  state_d = StMemWr;
                        ClsJmp:  state_d = StJump;
                        default: state_d = StFetch;
                    endcase
                end
            end
            StMemRd, StMemWr: if (mem_ready) state_d = StFetch;
            StAlu1:                  state_d = StAlu2;
            StAlu2, StXfer, StJump:  state_d = StFetch;
            StHalt:                  state_d = StHalt;
            default:                 state_d = StFetch;
        endcase

        // Stall cycles count up; wait_d defaults to zero so leaving the state clears it.
        if (is_bus_state(state_q) && !mem_ready) begin
            if (wait_q == WaitW'(WAIT_MAX - 1)) begin
                timeout_d = 1'b1;
                state_d   = StHalt;
            end else begin
                wait_d = wait_q + WaitW'(1);
            end
        end
    end

    assign bus_timeout = timeout_q & ~rst;

    // Reset gates every strobe so an abandoned instruction never touches the datapath.
    always_comb begin
        mem_rd          = 1'b0;
        mem_wr          = 1'b0;
        pr_on_add       = 1'b0;
        ar_on_add       = 1'b0;
        pr_on_data      = 1'b0;
        ir_on_data      = 1'b0;
        ar_on_data      = 1'b0;
        dr_on_data      = 1'b0;
        gr_on_data      = 1'b0;
        alu_2_data      = 1'b0;
        load_FR_On_data = 1'b0;
        data_on_ir      = 1'b0;
        data_on_ar      = 1'b0;
        data_on_dr      = 1'b0;
        lsb_on_gr       = 1'b0;
        msb_on_gr       = 1'b0;
        ar_on_pr        = 1'b0;
        increment_pr    = 1'b0;
        ALU_sel         = 1'b0;
        ALU_cin         = 1'b0;
        add_sel_a       = 2'b00;
        add_sel_b       = 2'b00;
        halted          = 1'b0;
        illegal_op      = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    pr_on_add    = 1'b1;
                    mem_rd       = 1'b1;
                    data_on_ir   = mem_ready;
                    increment_pr = mem_ready;
                end
                StDecode: illegal_op = illegal;
                StOpnd: begin
                    pr_on_add    = 1'b1;
                    mem_rd       = 1'b1;
                    increment_pr = mem_ready;
                    if (iclass == ClsLdi) data_on_dr = mem_ready;
                    else                  data_on_ar = mem_ready;
                end
                StMemRd: begin
                    ar_on_add  = 1'b1;
                    mem_rd     = 1'b1;
                    data_on_dr = mem_ready;
                end
                StMemWr: begin
                    ar_on_add  = 1'b1;
                    dr_on_data = 1'b1;
                    mem_wr     = 1'b1;
                end
                StAlu1, StAlu2: begin
                    add_sel_a  = sel_a;
                    add_sel_b  = sel_b;
                    ALU_sel    = alu_op;
                    ALU_cin    = (alu_op == ALU_SUB);
                    alu_2_data = (state_q == StAlu2);
                    data_on_dr = (state_q == StAlu2);
                end
                StXfer: begin
                    case (iclass)
                        ClsMvg: begin
                            dr_on_data = 1'b1;
                            lsb_on_gr  = ~gr_msb;
                            msb_on_gr  = gr_msb;
                        end
                        ClsRdf: begin
                            load_FR_On_data = 1'b1;
                            data_on_dr      = 1'b1;
                        end
                        ClsRdg: begin
                            gr_on_data = 1'b1;
                            data_on_dr = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StJump:  ar_on_pr = 1'b1;
                StHalt:  halted   = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction phase lists from the
// instruction set description, random memory stalls and directed corner cases.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int WAIT_MAX = 15;

    typedef enum {
        PhFetch, PhDecode, PhOpnd, PhMemrd, PhMemwr, PhAlu1, PhAlu2, PhXfer, PhJump, PhHalt
    } phase_e;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       pr_on_add;
        logic       ar_on_add;
        logic       pr_on_data;
        logic       ir_on_data;
        logic       ar_on_data;
        logic       dr_on_data;
        logic       gr_on_data;
        logic       alu_2_data;
        logic       load_fr_on_data;
        logic       data_on_ir;
        logic       data_on_ar;
        logic       data_on_dr;
        logic       lsb_on_gr;
        logic       msb_on_gr;
        logic       ar_on_pr;
        logic       increment_pr;
        logic       alu_sel;
        logic       alu_cin;
        logic [1:0] add_sel_a;
        logic [1:0] add_sel_b;
        logic       halted;
        logic       illegal_op;
        logic       bus_timeout;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] machine_code;
    logic       mem_ready;
    logic mem_rd, mem_wr, pr_on_add, ar_on_add;
    logic pr_on_data, ir_on_data, ar_on_data, dr_on_data, gr_on_data, alu_2_data;
    logic load_FR_On_data, data_on_ir, data_on_ar, data_on_dr, lsb_on_gr, msb_on_gr;
    logic ar_on_pr, increment_pr, ALU_sel, ALU_cin, halted, illegal_op, bus_timeout;
    logic [1:0] add_sel_a, add_sel_b;

    int n_tests = 0;
    int n_fail  = 0;
    outs_t got;

    assign got = {mem_rd, mem_wr, pr_on_add, ar_on_add, pr_on_data, ir_on_data, ar_on_data,
                  dr_on_data, gr_on_data, alu_2_data, load_FR_On_data, data_on_ir, data_on_ar,
                  data_on_dr, lsb_on_gr, msb_on_gr, ar_on_pr, increment_pr, ALU_sel, ALU_cin,
                  add_sel_a, add_sel_b, halted, illegal_op, bus_timeout};

    control_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .machine_code(machine_code), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .pr_on_add(pr_on_add), .ar_on_add(ar_on_add),
        .pr_on_data(pr_on_data), .ir_on_data(ir_on_data), .ar_on_data(ar_on_data),
        .dr_on_data(dr_on_data), .gr_on_data(gr_on_data), .alu_2_data(alu_2_data),
        .load_FR_On_data(load_FR_On_data), .data_on_ir(data_on_ir), .data_on_ar(data_on_ar),
        .data_on_dr(data_on_dr), .lsb_on_gr(lsb_on_gr), .msb_on_gr(msb_on_gr),
        .ar_on_pr(ar_on_pr), .increment_pr(increment_pr), .ALU_sel(ALU_sel),
        .ALU_cin(ALU_cin), .add_sel_a(add_sel_a), .add_sel_b(add_sel_b), .halted(halted),
        .illegal_op(illegal_op), .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    // Expected strobes for one cycle of an instruction phase.
    function automatic outs_t exp_out(phase_e p, logic [7:0] instr, logic rdy);
        outs_t      o;
        logic [3:0] op;
        o  = '0;
        op = instr[7:4];
        case (p)
            PhFetch: begin
                o.pr_on_add = 1'b1; o.mem_rd = 1'b1;
                o.data_on_ir = rdy; o.increment_pr = rdy;
            end
            PhDecode: o.illegal_op = (op >= 4'hA && op <= 4'hE);
            PhOpnd: begin
                o.pr_on_add = 1'b1; o.mem_rd = 1'b1; o.increment_pr = rdy;
                if (op == OP_LDI) o.data_on_dr = rdy;
                else              o.data_on_ar = rdy;
            end
            PhMemrd: begin
                o.ar_on_add = 1'b1; o.mem_rd = 1'b1; o.data_on_dr = rdy;
            end
            PhMemwr: begin
                o.ar_on_add = 1'b1; o.dr_on_data = 1'b1; o.mem_wr = 1'b1;
            end
            PhAlu1, PhAlu2: begin
                o.add_sel_a = instr[3:2]; o.add_sel_b = instr[1:0];
                o.alu_sel = (op == OP_SUB); o.alu_cin = (op == OP_SUB);
                o.alu_2_data = (p == PhAlu2); o.data_on_dr = (p == PhAlu2);
            end
            PhXfer: begin
                if (op == OP_MVG) begin
                    o.dr_on_data = 1'b1; o.lsb_on_gr = ~instr[0]; o.msb_on_gr = instr[0];
                end else if (op == OP_RDF) begin
                    o.load_fr_on_data = 1'b1; o.data_on_dr = 1'b1;
                end else begin
                    o.gr_on_data = 1'b1; o.data_on_dr = 1'b1;
                end
            end
            PhJump: o.ar_on_pr = 1'b1;
            PhHalt: o.halted = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'($urandom);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Runs one instruction from FETCH; stall < 0 draws 0..3 stall cycles per bus access.
    task automatic run_instr(input logic [7:0] instr, input int stall, input string tag);
        phase_e ph[$];
        outs_t  exp;
        int     n;
        logic   is_bus;
        case (instr[7:4])
            OP_LDA:         ph = '{PhFetch, PhDecode, PhOpnd, PhMemrd};
            OP_STA:         ph = '{PhFetch, PhDecode, PhOpnd, PhMemwr};
            OP_ADD, OP_SUB: ph = '{PhFetch, PhDecode, PhAlu1, PhAlu2};
            OP_LDI:         ph = '{PhFetch, PhDecode, PhOpnd};
            OP_JMP:         ph = '{PhFetch, PhDecode, PhOpnd, PhJump};
            OP_MVG, OP_RDF, OP_RDG: ph = '{PhFetch, PhDecode, PhXfer};
            default:        ph = '{PhFetch, PhDecode};
        endcase
        foreach (ph[i]) begin
            is_bus = (ph[i] == PhFetch) || (ph[i] == PhOpnd) || (ph[i] == PhMemrd) ||
                     (ph[i] == PhMemwr);
            n = !is_bus ? 0 : (stall < 0 ? int'($urandom_range(3, 0)) : stall);
            for (int s = 0; s <= n; s++) begin
                mem_ready = is_bus ? (s == n) : 1'($urandom);
                @(negedge clk);
                exp = exp_out(ph[i], instr, mem_ready);
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL %s instr=%h %s cyc%0d: got %h want %h",
                             tag, instr, ph[i].name(), s, got, exp);
                end
                n_tests++;
                if ($countones({pr_on_data, ir_on_data, ar_on_data, dr_on_data, gr_on_data,
                                alu_2_data, load_FR_On_data}) > 1 ||
                    (pr_on_add && ar_on_add) || (mem_rd && mem_wr)) begin
                    n_fail++;
                    $display("FAIL %s bus_onehot instr=%h: got %h want at most one driver",
                             tag, instr, got);
                end
                @(posedge clk); #1;
            end
            if (ph[i] == PhFetch) machine_code = instr;
        end
    endtask

    task automatic test_reset();
        outs_t exp;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            machine_code = 8'($urandom);
            mem_ready    = 1'($urandom);
            @(negedge clk);
            n_tests++;
            if (got !== '0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got %h want 0", c, got);
            end
            @(posedge clk); #1;
        end
        rst       = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        exp = exp_out(PhFetch, 8'h00, 1'b0);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_exit: got %h want %h", got, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_nop();
        run_instr(8'h00, 0, "nop");
        run_instr(8'h0B, 1, "nop_stall");
    endtask

    task automatic test_ldi_stall();
        run_instr(8'h5C, 2, "ldi_stall");
    endtask

    task automatic test_alu();
        run_instr({OP_ADD, SEL_GR, SEL_DR}, 0, "add_39");
        run_instr({OP_SUB, SEL_PR, SEL_AR}, 0, "sub");
    endtask

    task automatic test_back_to_back();
        run_instr(8'h2A, 1, "sta");
        run_instr(8'h63, 0, "jmp");
        run_instr(8'h17, 2, "lda");
    endtask

    task automatic test_xfer();
        run_instr(8'h70, 0, "mvg_lsb");
        run_instr(8'h71, 0, "mvg_msb");
        run_instr(8'h80, 0, "rdf");
        run_instr(8'h9F, 0, "rdg");
    endtask

    task automatic test_illegal();
        run_instr(8'hA5, 0, "illegal_a");
        run_instr(8'hE0, 1, "illegal_e");
    endtask

    task automatic test_halt();
        outs_t exp;
        run_instr({OP_HLT, 4'h0}, 0, "hlt");
        for (int c = 0; c < 3; c++) begin
            mem_ready    = 1'($urandom);
            machine_code = 8'($urandom);
            @(negedge clk);
            exp = exp_out(PhHalt, 8'h00, 1'b0);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL halt_hold cyc%0d: got %h want %h", c, got, exp);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL halt_rst: got %h want 0", got);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        exp = exp_out(PhFetch, 8'h00, 1'b0);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL halt_resume: got %h want %h", got, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        outs_t exp;
        do_reset();
        mem_ready = 1'b0;
        for (int c = 0; c < WAIT_MAX; c++) begin
            @(negedge clk);
            exp = exp_out(PhFetch, 8'h00, 1'b0);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL timeout_wait cyc%0d: got %h want %h", c, got, exp);
            end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            exp = exp_out(PhHalt, 8'h00, 1'b0);
            exp.bus_timeout = 1'b1;
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL timeout_halt cyc%0d: got %h want %h", c, got, exp);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        exp = exp_out(PhFetch, 8'h00, 1'b0);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL timeout_clear: got %h want %h", got, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_alu();
        outs_t exp;
        mem_ready = 1'b1;
        @(negedge clk);
        exp = exp_out(PhFetch, 8'h00, 1'b1);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL midrst_fetch: got %h want %h", got, exp);
        end
        @(posedge clk); #1;
        machine_code = 8'h4E;
        @(negedge clk);
        n_tests++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL midrst_decode: got %h want 0", got);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL midrst_alu1: got %h want 0", got);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        exp = exp_out(PhFetch, 8'h00, 1'b0);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL midrst_refetch: got %h want %h", got, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [7:0] instr;
        for (int k = 0; k < 40; k++) begin
            instr = {4'($urandom_range(14, 0)), 4'($urandom)};
            run_instr(instr, -1, "random");
        end
    endtask

    initial begin
        rst          = 1'b1;
        machine_code = 8'h00;
        mem_ready    = 1'b0;
        test_reset();
        test_nop();
        test_ldi_stall();
        test_alu();
        test_back_to_back();
        test_xfer();
        test_illegal();
        test_halt();
        test_random();
        test_reset_mid_alu();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
